// File: rtl/sync_width_fifo_pkg.sv
// Shared helpers for the width-converting FIFO:
// sizing, lane slicing and configuration checks.
package sync_width_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Bit offset of narrow lane `lane` inside a wide word.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic bit width_ok(input int wr_w, input int rd_w,
                                    input int ratio);
        return (wr_w == ratio * rd_w) &&
               (ratio == 1 || ratio == 2 || ratio == 4 || ratio == 8);
    endfunction

endpackage

// File: rtl/sync_width_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A same-address read and write return the old contents.
module sync_width_fifo_ram #(
    parameter int WIDTH = 128,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_width_fifo.sv
// Single-clock FIFO: wide words in, narrow lanes out (lane 0 first),
// with optional first-word-fall-through and sticky error flags.
module sync_width_fifo
    import sync_width_fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH    = 128,
    parameter int RD_DATA_WIDTH    = 32,
    parameter int RATIO            = 4,
    parameter int WR_DEPTH_WIDTH   = 10,
    parameter int RD_DEPTH_WIDTH   = WR_DEPTH_WIDTH + clog2(RATIO),
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW  = WR_DEPTH_WIDTH;
    localparam int PW  = AW + 1;
    localparam int RW  = RD_DEPTH_WIDTH + 1;
    localparam int LW  = clog2(RATIO);
    localparam int LWS = (LW > 0) ? LW : 1;
    localparam logic [PW-1:0] CAP = {1'b1, {AW{1'b0}}};
    localparam bit CFG_OK = width_ok(WR_DATA_WIDTH, RD_DATA_WIDTH, RATIO);

    if (!CFG_OK) begin : g_bad_cfg
        $error("sync_width_fifo: WR_DATA_WIDTH must be RATIO*RD_DATA_WIDTH");
    end

    logic [PW-1:0]            wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [PW-1:0]            wr_lvl_n;
    logic [RW-1:0]            rd_lvl_n;
    logic [LWS-1:0]           lane, lane_n;
    logic                     lane_last;
    logic                     clear, wr_acc, rd_acc;
    logic                     pf_fill, empty_n;
    logic                     ram_we, ram_re;
    logic [AW-1:0]            raddr;
    logic [WR_DATA_WIDTH-1:0] ram_q;

    assign clear  = rst | flush;
    assign wr_acc = wr_en & ~wr_full;
    assign rd_acc = rd_en & ~rd_empty;
    assign ram_we = wr_acc & ~clear;

    if (RATIO == 1) begin : g_one
        assign lane_last = 1'b1;
        assign lane_n    = '0;
        assign rd_lvl_n  = RW'(wr_lvl_n);
    end else begin : g_lanes
        assign lane_last = (lane == LWS'(RATIO - 1));
        always_comb begin
            lane_n = lane;
            if (clear)       lane_n = '0;
            else if (rd_acc) lane_n = lane_last ? '0 : lane + LWS'(1);
        end
        assign rd_lvl_n = {wr_lvl_n, {LW{1'b0}}} - RW'(lane_n);
    end

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        if (clear) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            if (wr_acc)              wr_ptr_n = wr_ptr + PW'(1);
            if (rd_acc && lane_last) rd_ptr_n = rd_ptr + PW'(1);
        end
    end

    assign wr_lvl_n = wr_ptr_n - rd_ptr_n;
    // Head entry is readable from RAM next cycle only if already stored now.
    assign pf_fill  = ~clear & (rd_ptr_n != wr_ptr);
    assign empty_n  = (rd_lvl_n == '0) || ((FWFT != 0) && !pf_fill);

    always_ff @(posedge clk) begin
        wr_ptr         <= wr_ptr_n;
        rd_ptr         <= rd_ptr_n;
        lane           <= lane_n;
        wr_water_level <= wr_lvl_n;
        rd_water_level <= rd_lvl_n;
        wr_full        <= (wr_lvl_n == CAP);
        almost_full    <= (wr_lvl_n >= PW'(ALMOST_FULL_NUM));
        rd_empty       <= empty_n;
        almost_empty   <= (rd_lvl_n <= RW'(ALMOST_EMPTY_NUM));
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && wr_full)  overflow  <= 1'b1;
            if (rd_en && rd_empty) underflow <= 1'b1;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign raddr    = rd_ptr_n[AW-1:0];
        assign ram_re   = 1'b1;
        assign rd_valid = ~rd_empty;
        assign rd_data  = rd_empty ? '0 :
            ram_q[lane_lsb(int'(lane), RD_DATA_WIDTH) +: RD_DATA_WIDTH];
    end else begin : g_std
        logic [LWS-1:0] sel;
        logic           hold_zero;

        assign raddr  = rd_ptr[AW-1:0];
        assign ram_re = rd_acc;

        always_ff @(posedge clk) begin
            rd_valid <= rd_acc & ~clear;
            if (clear)       hold_zero <= 1'b1;
            else if (rd_acc) hold_zero <= 1'b0;
            if (rd_acc) sel <= lane;
        end

        // RAM output is held between pops, so rd_data keeps its value.
        assign rd_data = hold_zero ? '0 :
            ram_q[lane_lsb(int'(sel), RD_DATA_WIDTH) +: RD_DATA_WIDTH];
    end

    sync_width_fifo_ram #(
        .WIDTH (WR_DATA_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (ram_q)
    );

endmodule

// File: doc/sync_width_fifo.md
Name: sync_width_fifo

Overview:
- Single-clock FIFO with down-conversion from a wide write word to narrow read words, WR_DATA_WIDTH = RATIO × RD_DATA_WIDTH.
- Successor to the dual-clock 128→32 FIFO wrapper. Adds a parametrised ratio, a selectable first-word-fall-through read mode, synchronous flush, a read-valid strobe, and sticky overflow/underflow flags.
- Sits between the wide DDR read path and narrow pixel-stream consumers inside a single clock domain.

Parameters:
- WR_DATA_WIDTH, 128, write word width; must equal RATIO × RD_DATA_WIDTH.
- RD_DATA_WIDTH, 32, read word width.
- RATIO, 4, lanes per write word; legal values 1, 2, 4, 8.
- WR_DEPTH_WIDTH, 10, log2 of capacity in write words (1024).
- RD_DEPTH_WIDTH, WR_DEPTH_WIDTH+log2(RATIO), derived; do not override.
- FWFT, 0. 0 = standard read with one-cycle latency; 1 = first-word-fall-through.
- ALMOST_FULL_NUM, 1020, threshold in write words.
- ALMOST_EMPTY_NUM, 4, threshold in read words.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents and pointers; takes effect at the same edge.
- wr_en  in  1  write request.
- wr_data  in  WR_DATA_WIDTH  write word.
- wr_full  out  1  full flag.
- almost_full  out  1  asserted when wr_water_level >= ALMOST_FULL_NUM.
- wr_water_level  out  WR_DEPTH_WIDTH+1  write words occupied, counting a partially read word.
- rd_en  in  1  read request (pop).
- rd_data  out  RD_DATA_WIDTH  read word.
- rd_valid  out  1  rd_data qualifier.
- rd_empty  out  1  empty flag.
- almost_empty  out  1  asserted when rd_water_level <= ALMOST_EMPTY_NUM.
- rd_water_level  out  RD_DEPTH_WIDTH+1  read words available.
- overflow  out  1  sticky; set by wr_en while wr_full.
- underflow  out  1  sticky; set by rd_en while rd_empty.

Behaviour:
- Reset values: rd_empty=1, almost_empty=1; every other output 0, including rd_data, the water levels, and the sticky flags.
- Storage: 2^WR_DEPTH_WIDTH wide entries in a simple dual-port RAM with a registered read. Write pointer and read pointer are WR_DEPTH_WIDTH+1 bits, with the MSB used for wrap. A lane counter, log2(RATIO) bits, selects the current sub-word.
- Lane order: lane 0 = wr_data[RD_DATA_WIDTH-1:0] is read first; the MSB slice is read last.
- Write accept: wr_en && !wr_full. The entry is stored and wr_ptr increments at that edge. A write while full is dropped and sets overflow.
- Read accept: rd_en && !rd_empty, counted in narrow words. The lane advances on each accept. On the last lane, the lane returns to 0 and rd_ptr increments; the wide entry is freed only at that point.
- A read while empty is ignored and sets underflow.
- Counts:
  - wr_water_level = wr_ptr - rd_ptr.
  - rd_water_level = wr_water_level × RATIO - lane.
  - wr_full = (wr_water_level == 2^WR_DEPTH_WIDTH).
  - rd_empty = (rd_water_level == 0), subject to the FWFT rule below.
- All flags and levels are registered and update on the edge following the causing accept.
- Simultaneous write and read accepts are both honoured:
  - wr_water_level changes by +1, or by 0 if the read frees an entry.
  - rd_water_level changes by +RATIO-1.
  - Writing while full is not allowed even if a read is simultaneous; that write is dropped. This is a deliberate conservative full.
- FWFT=0: a read accepted at edge N gives rd_data and rd_valid=1 during cycle N+1. rd_valid is low otherwise, and rd_data holds its last value. A write into an empty FIFO at edge N gives rd_empty=0 in cycle N+1.
- FWFT=1:
  - An internal prefetch register holds the head word.
  - rd_valid = !rd_empty, and rd_data shows the head combinationally from that register.
  - Write into empty at edge N: rd_empty=0 in cycle N+2, due to RAM plus prefetch latency. The level counters still update at N+1, but rd_empty is gated by prefetch valid.
  - A pop at edge N presents the next lane or entry in cycle N+1, with no bubble while the FIFO is non-empty.
- Flush or rst: pointers, lane counter and prefetch are cleared and outputs return to reset values. Any write or read accepted in the same cycle is discarded.
  - rst clears overflow and underflow.
  - flush does not clear overflow or underflow.
- RATIO=1 degenerates to a plain synchronous FIFO with a zero-width lane counter, guarded with a generate branch.

Decomposition:
- Package sync_width_fifo_pkg holds:
  - the function clog2;
  - the lane-select helper;
  - the localparam check for WR_DATA_WIDTH == RATIO × RD_DATA_WIDTH, which triggers $error at elaboration on mismatch.
- One sub-module, sync_width_fifo_ram: a simple dual-port RAM with registered read, WR_DATA_WIDTH × 2^WR_DEPTH_WIDTH.
- Pointers, lane select, FWFT prefetch and flags stay in the top module.

Test Plan:
- Basic down-conversion, FWFT=0, RATIO=4: write 0x4444_4444_3333_3333_2222_2222_1111_1111, then rd_en for 4 cycles. rd_data must read 0x11111111, 0x22222222, 0x33333333, 0x44444444, each one cycle after its accept with rd_valid=1. rd_empty must rise after the 4th accept.
- Fill to full: 1024 writes give wr_full=1 and almost_full=1 from the 1020th write. A 1025th write sets overflow and the contents are unchanged. 3 reads leave wr_full=1; the 4th read clears wr_full on the next cycle.
- Simultaneous write and read at level 1 word with lane 3: rd_water_level goes 1 → 4 and wr_water_level stays 1.
- FWFT=1 latency: write at edge N gives rd_empty=0 and rd_data=lane 0 in cycle N+2. Then 4 back-to-back pops must show every lane with no gap.
- Flush mid-stream: with 10 words stored and lane 2, assert flush together with wr_en and rd_en. The next cycle must show rd_empty=1, both levels 0, and an overflow value set earlier retained. rst then clears overflow.
- Underflow: rd_en while empty sets underflow, rd_valid stays 0 and the pointers are unchanged.
